// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: state encoding,
// opcode/funct values, mux select encodings and the packed control bundle.
package mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WR   = 4'd4,
        ST_WB_MEM   = 4'd5,
        ST_EXEC_R   = 4'd6,
        ST_WB_R     = 4'd7,
        ST_EXEC_I   = 4'd8,
        ST_WB_I     = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_JR       = 4'd12,
        ST_ILLEGAL  = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2a;
    localparam logic [5:0] FN_SLTU  = 6'h2b;

    localparam logic [2:0] CLS_LW      = 3'd0;
    localparam logic [2:0] CLS_SW      = 3'd1;
    localparam logic [2:0] CLS_RTYPE   = 3'd2;
    localparam logic [2:0] CLS_JR      = 3'd3;
    localparam logic [2:0] CLS_BRANCH  = 3'd4;
    localparam logic [2:0] CLS_JUMP    = 3'd5;
    localparam logic [2:0] CLS_IMM     = 3'd6;
    localparam logic [2:0] CLS_ILLEGAL = 3'd7;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG    = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_REG   = 2'b01;
    localparam logic [1:0] SRCA_SHAMT = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BOFF  = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OPC   = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       ext_op;
        logic       lu_op;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: maps opcode/funct onto the FSM's
// instruction class plus the per-instruction flags used in execute states.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] instr_class,
    output logic       is_link,
    output logic       is_bne,
    output logic       is_shamt,
    output logic       ext_imm,
    output logic       lu_sel
);

    always_comb begin
        instr_class = CLS_ILLEGAL;
        is_link     = 1'b0;
        is_bne      = 1'b0;
        is_shamt    = 1'b0;
        ext_imm     = 1'b1;
        lu_sel      = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_SLL, FN_SRL, FN_SRA: begin
                        instr_class = CLS_RTYPE;
                        is_shamt    = 1'b1;
                    end
                    FN_SLLV, FN_SRLV, FN_SRAV,
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                    FN_AND, FN_OR, FN_XOR, FN_NOR,
                    FN_SLT, FN_SLTU: instr_class = CLS_RTYPE;
                    FN_JR:   instr_class = CLS_JR;
                    FN_JALR: begin
                        instr_class = CLS_JR;
                        is_link     = 1'b1;
                    end
                    default: instr_class = CLS_ILLEGAL;
                endcase
            end
            OP_LW:  instr_class = CLS_LW;
            OP_SW:  instr_class = CLS_SW;
            OP_BEQ: instr_class = CLS_BRANCH;
            OP_BNE: begin
                instr_class = CLS_BRANCH;
                is_bne      = 1'b1;
            end
            OP_J:   instr_class = CLS_JUMP;
            OP_JAL: begin
                instr_class = CLS_JUMP;
                is_link     = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: instr_class = CLS_IMM;
            // logical immediates take a zero-extended operand
            OP_ANDI, OP_ORI: begin
                instr_class = CLS_IMM;
                ext_imm     = 1'b0;
            end
            OP_LUI: begin
                instr_class = CLS_IMM;
                lu_sel      = 1'b1;
            end
            default: instr_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences shared memory, ALU and register file,
// holding memory states until mem_ready so one FSM serves BRAM and slow memory.
//
//  state     | meaning
//  FETCH     | read instruction at PC, PC += 4 when memory answers
//  DECODE    | read registers, precompute branch target
//  MEM_ADDR  | ALUOut = A + sext(imm)
//  MEM_RD    | load from ALUOut, wait for mem_ready
//  MEM_WR    | store to ALUOut, wait for mem_ready, then done
//  WB_MEM    | rt = MDR
//  EXEC_R    | ALU by funct
//  WB_R      | rd = ALUOut
//  EXEC_I    | ALU by opcode with immediate
//  WB_I      | rt = ALUOut
//  BRANCH    | compare A - B, conditional PC load
//  JUMP      | PC = jump target (jal links $31)
//  JR        | PC = A (jalr links rd)
//  ILLEGAL   | flag unknown instruction, no writes
module multicycle_controller
    import mc_pkg::*;
#(
    parameter bit HAS_WAIT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic [1:0] pc_source,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       ext_op,
    output logic       lu_op,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t     state_q;
    state_t     state_d;
    ctrl_t      ctl;
    logic       ready;
    logic [2:0] instr_class;
    logic       is_link;
    logic       is_bne;
    logic       is_shamt;
    logic       ext_imm;
    logic       lu_sel;

    assign ready = HAS_WAIT ? mem_ready : 1'b1;

    mc_decode u_decode (
        .opcode      (opcode),
        .funct       (funct),
        .instr_class (instr_class),
        .is_link     (is_link),
        .is_bne      (is_bne),
        .is_shamt    (is_shamt),
        .ext_imm     (ext_imm),
        .lu_sel      (lu_sel)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH: state_d = ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (instr_class)
                    CLS_LW, CLS_SW: state_d = ST_MEM_ADDR;
                    CLS_RTYPE:      state_d = ST_EXEC_R;
                    CLS_JR:         state_d = ST_JR;
                    CLS_BRANCH:     state_d = ST_BRANCH;
                    CLS_JUMP:       state_d = ST_JUMP;
                    CLS_IMM:        state_d = ST_EXEC_I;
                    default:        state_d = ST_ILLEGAL;
                endcase
            end
            ST_MEM_ADDR: state_d = (instr_class == CLS_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   state_d = ready ? ST_WB_MEM : ST_MEM_RD;
            ST_MEM_WR:   state_d = ready ? ST_FETCH : ST_MEM_WR;
            ST_EXEC_R:   state_d = ST_WB_R;
            ST_EXEC_I:   state_d = ST_WB_I;
            default:     state_d = ST_FETCH;
        endcase
    end

    // Reset forces every control line low so a half-finished access is dropped.
    always_comb begin
        ctl = '0;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    ctl.mem_read  = 1'b1;
                    ctl.alu_src_b = SRCB_FOUR;
                    ctl.alu_op    = ALU_ADD;
                    ctl.pc_source = PCSRC_ALU;
                    ctl.ir_write  = ready;
                    ctl.pc_write  = ready;
                end
                ST_DECODE: begin
                    ctl.alu_src_b = SRCB_BOFF;
                    ctl.alu_op    = ALU_ADD;
                    ctl.ext_op    = 1'b1;
                end
                ST_MEM_ADDR: begin
                    ctl.alu_src_a = SRCA_REG;
                    ctl.alu_src_b = SRCB_IMM;
                    ctl.ext_op    = 1'b1;
                    ctl.alu_op    = ALU_ADD;
                end
                ST_MEM_RD: begin
                    ctl.iord     = 1'b1;
                    ctl.mem_read = 1'b1;
                end
                ST_MEM_WR: begin
                    ctl.iord       = 1'b1;
                    ctl.mem_write  = 1'b1;
                    ctl.instr_done = ready;
                end
                ST_WB_MEM: begin
                    ctl.reg_write  = 1'b1;
                    ctl.reg_dst    = REGDST_RT;
                    ctl.mem_to_reg = M2R_MDR;
                    ctl.instr_done = 1'b1;
                end
                ST_EXEC_R: begin
                    ctl.alu_src_a = is_shamt ? SRCA_SHAMT : SRCA_REG;
                    ctl.alu_src_b = SRCB_REG;
                    ctl.alu_op    = ALU_FUNCT;
                end
                ST_WB_R: begin
                    ctl.reg_write  = 1'b1;
                    ctl.reg_dst    = REGDST_RD;
                    ctl.mem_to_reg = M2R_ALUOUT;
                    ctl.instr_done = 1'b1;
                end
                ST_EXEC_I: begin
                    ctl.alu_src_a = SRCA_REG;
                    ctl.alu_src_b = SRCB_IMM;
                    ctl.alu_op    = ALU_OPC;
                    ctl.ext_op    = ext_imm;
                    ctl.lu_op     = lu_sel;
                end
                ST_WB_I: begin
                    ctl.reg_write  = 1'b1;
                    ctl.reg_dst    = REGDST_RT;
                    ctl.mem_to_reg = M2R_ALUOUT;
                    ctl.instr_done = 1'b1;
                end
                ST_BRANCH: begin
                    ctl.alu_src_a     = SRCA_REG;
                    ctl.alu_src_b     = SRCB_REG;
                    ctl.alu_op        = ALU_SUB;
                    ctl.pc_write_cond = 1'b1;
                    ctl.pc_source     = PCSRC_ALUOUT;
                    ctl.branch_ne     = is_bne;
                    ctl.instr_done    = 1'b1;
                end
                ST_JUMP: begin
                    ctl.pc_write   = 1'b1;
                    ctl.pc_source  = PCSRC_JUMP;
                    ctl.reg_write  = is_link;
                    ctl.reg_dst    = is_link ? REGDST_RA : REGDST_RT;
                    ctl.mem_to_reg = is_link ? M2R_PC : M2R_ALUOUT;
                    ctl.instr_done = 1'b1;
                end
                ST_JR: begin
                    ctl.pc_write   = 1'b1;
                    ctl.pc_source  = PCSRC_REG;
                    ctl.reg_write  = is_link;
                    ctl.reg_dst    = is_link ? REGDST_RD : REGDST_RT;
                    ctl.mem_to_reg = is_link ? M2R_PC : M2R_ALUOUT;
                    ctl.instr_done = 1'b1;
                end
                ST_ILLEGAL: begin
                    ctl.illegal_op = 1'b1;
                    ctl.instr_done = 1'b1;
                end
                default: ctl = '0;
            endcase
        end
    end

    assign pc_write      = ctl.pc_write;
    assign pc_write_cond = ctl.pc_write_cond;
    assign branch_ne     = ctl.branch_ne;
    assign pc_source     = ctl.pc_source;
    assign iord          = ctl.iord;
    assign mem_read      = ctl.mem_read;
    assign mem_write     = ctl.mem_write;
    assign ir_write      = ctl.ir_write;
    assign reg_write     = ctl.reg_write;
    assign reg_dst       = ctl.reg_dst;
    assign mem_to_reg    = ctl.mem_to_reg;
    assign alu_src_a     = ctl.alu_src_a;
    assign alu_src_b     = ctl.alu_src_b;
    assign alu_op        = ctl.alu_op;
    assign ext_op        = ctl.ext_op;
    assign lu_op         = ctl.lu_op;
    assign instr_done    = ctl.instr_done;
    assign illegal_op    = ctl.illegal_op;
    assign state         = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: each cycle's expected state and
// control bundle is queued when stimulus is driven and checked at the falling edge.
module tb_multicycle_controller;
    import mc_pkg::state_t;
    import mc_pkg::ST_FETCH;
    import mc_pkg::ST_DECODE;
    import mc_pkg::ST_MEM_ADDR;
    import mc_pkg::ST_MEM_RD;
    import mc_pkg::ST_MEM_WR;
    import mc_pkg::ST_WB_MEM;
    import mc_pkg::ST_EXEC_R;
    import mc_pkg::ST_WB_R;
    import mc_pkg::ST_EXEC_I;
    import mc_pkg::ST_WB_I;
    import mc_pkg::ST_BRANCH;
    import mc_pkg::ST_JUMP;
    import mc_pkg::ST_JR;
    import mc_pkg::ST_ILLEGAL;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       ext_op;
        logic       lu_op;
        logic       instr_done;
        logic       illegal_op;
    } tb_ctl_t;

    typedef struct {
        string      tag;
        logic [3:0] st;
        tb_ctl_t    ctl;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
    logic       ir_write, reg_write, ext_op, lu_op, instr_done, illegal_op;
    logic [1:0] pc_source, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op;
    logic [3:0] state;
    tb_ctl_t    obs;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.HAS_WAIT(1'b1)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct         (funct),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_ne     (branch_ne),
        .pc_source     (pc_source),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .ext_op        (ext_op),
        .lu_op         (lu_op),
        .instr_done    (instr_done),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    assign obs = {pc_write, pc_write_cond, branch_ne, pc_source, iord, mem_read,
                  mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
                  alu_src_b, alu_op, ext_op, lu_op, instr_done, illegal_op};

    function automatic tb_ctl_t c_fetch(input logic r);
        tb_ctl_t c = '0;
        c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = r; c.pc_write = r;
        return c;
    endfunction

    function automatic tb_ctl_t c_decode();
        tb_ctl_t c = '0;
        c.alu_src_b = 2'b11; c.ext_op = 1'b1;
        return c;
    endfunction

    function automatic tb_ctl_t c_mem_addr();
        tb_ctl_t c = '0;
        c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.ext_op = 1'b1;
        return c;
    endfunction

    function automatic tb_ctl_t c_mem_rd();
        tb_ctl_t c = '0;
        c.iord = 1'b1; c.mem_read = 1'b1;
        return c;
    endfunction

    function automatic tb_ctl_t c_mem_wr(input logic r);
        tb_ctl_t c = '0;
        c.iord = 1'b1; c.mem_write = 1'b1; c.instr_done = r;
        return c;
    endfunction

    function automatic tb_ctl_t c_wb_mem();
        tb_ctl_t c = '0;
        c.reg_write = 1'b1; c.mem_to_reg = 2'b01; c.instr_done = 1'b1;
        return c;
    endfunction

    function automatic tb_ctl_t c_exec_r(input logic shamt);
        tb_ctl_t c = '0;
        c.alu_src_a = shamt ? 2'b10 : 2'b01; c.alu_op = 2'b10;
        return c;
    endfunction

    function automatic tb_ctl_t c_wb_r();
        tb_ctl_t c = '0;
        c.reg_write = 1'b1; c.reg_dst = 2'b01; c.instr_done = 1'b1;
        return c;
    endfunction

    function automatic tb_ctl_t c_exec_i(input logic ext, input logic lu);
        tb_ctl_t c = '0;
        c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.alu_op = 2'b11;
        c.ext_op = ext; c.lu_op = lu;
        return c;
    endfunction

    function automatic tb_ctl_t c_wb_i();
        tb_ctl_t c = '0;
        c.reg_write = 1'b1; c.instr_done = 1'b1;
        return c;
    endfunction

    function automatic tb_ctl_t c_branch(input logic ne);
        tb_ctl_t c = '0;
        c.alu_src_a = 2'b01; c.alu_op = 2'b01; c.pc_write_cond = 1'b1;
        c.pc_source = 2'b01; c.branch_ne = ne; c.instr_done = 1'b1;
        return c;
    endfunction

    function automatic tb_ctl_t c_jump(input logic link);
        tb_ctl_t c = '0;
        c.pc_write = 1'b1; c.pc_source = 2'b10; c.instr_done = 1'b1;
        if (link) begin
            c.reg_write = 1'b1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10;
        end
        return c;
    endfunction

    function automatic tb_ctl_t c_jr(input logic link);
        tb_ctl_t c = '0;
        c.pc_write = 1'b1; c.pc_source = 2'b11; c.instr_done = 1'b1;
        if (link) begin
            c.reg_write = 1'b1; c.reg_dst = 2'b01; c.mem_to_reg = 2'b10;
        end
        return c;
    endfunction

    function automatic tb_ctl_t c_illegal();
        tb_ctl_t c = '0;
        c.illegal_op = 1'b1; c.instr_done = 1'b1;
        return c;
    endfunction

    // Queue the expectation for the cycle just driven, then compare at negedge.
    task automatic step(input string tag, input state_t st, input tb_ctl_t c);
        exp_t e;
        exp_t got;
        e.tag = tag;
        e.st  = st;
        e.ctl = c;
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        checks++;
        assert (state === got.st) else begin
            failures++;
            $error("FAIL %s state observed=%0d expected=%0d", got.tag, state, got.st);
        end
        checks++;
        assert (obs === got.ctl) else begin
            failures++;
            $error("FAIL %s ctl observed=%h expected=%h", got.tag, obs, got.ctl);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] fn);
        opcode    = op;
        funct     = fn;
        mem_ready = 1'b1;
        step("fetch", ST_FETCH, c_fetch(1'b1));
        step("decode", ST_DECODE, c_decode());
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b1;
        opcode    = 6'h00;
        funct     = 6'h20;
        @(posedge clk);
        #1;
        step("rst1", ST_FETCH, '0);
        step("rst2", ST_FETCH, '0);
        reset = 1'b0;

        // lw, zero wait
        instr(6'h23, 6'h00);
        step("lw_addr", ST_MEM_ADDR, c_mem_addr());
        step("lw_rd", ST_MEM_RD, c_mem_rd());
        step("lw_wb", ST_WB_MEM, c_wb_mem());

        // sw with three wait cycles
        instr(6'h2b, 6'h00);
        step("sw_addr", ST_MEM_ADDR, c_mem_addr());
        mem_ready = 1'b0;
        step("sw_wait1", ST_MEM_WR, c_mem_wr(1'b0));
        step("sw_wait2", ST_MEM_WR, c_mem_wr(1'b0));
        step("sw_wait3", ST_MEM_WR, c_mem_wr(1'b0));
        mem_ready = 1'b1;
        step("sw_commit", ST_MEM_WR, c_mem_wr(1'b1));

        instr(6'h05, 6'h00);
        step("bne", ST_BRANCH, c_branch(1'b1));
        instr(6'h04, 6'h00);
        step("beq", ST_BRANCH, c_branch(1'b0));

        instr(6'h03, 6'h00);
        step("jal", ST_JUMP, c_jump(1'b1));
        instr(6'h02, 6'h00);
        step("j", ST_JUMP, c_jump(1'b0));

        instr(6'h00, 6'h09);
        step("jalr", ST_JR, c_jr(1'b1));
        instr(6'h00, 6'h08);
        step("jr", ST_JR, c_jr(1'b0));

        instr(6'h00, 6'h20);
        step("add_ex", ST_EXEC_R, c_exec_r(1'b0));
        step("add_wb", ST_WB_R, c_wb_r());
        instr(6'h00, 6'h00);
        step("sll_ex", ST_EXEC_R, c_exec_r(1'b1));
        step("sll_wb", ST_WB_R, c_wb_r());

        instr(6'h0d, 6'h00);
        step("ori_ex", ST_EXEC_I, c_exec_i(1'b0, 1'b0));
        step("ori_wb", ST_WB_I, c_wb_i());
        instr(6'h0f, 6'h00);
        step("lui_ex", ST_EXEC_I, c_exec_i(1'b1, 1'b1));
        step("lui_wb", ST_WB_I, c_wb_i());
        instr(6'h08, 6'h00);
        step("addi_ex", ST_EXEC_I, c_exec_i(1'b1, 1'b0));
        step("addi_wb", ST_WB_I, c_wb_i());

        instr(6'h3f, 6'h00);
        step("ill_op", ST_ILLEGAL, c_illegal());
        instr(6'h00, 6'h3f);
        step("ill_fn", ST_ILLEGAL, c_illegal());

        // fetch stall, then lw aborted by reset while waiting in MEM_RD
        opcode    = 6'h23;
        mem_ready = 1'b0;
        step("fetch_wait", ST_FETCH, c_fetch(1'b0));
        mem_ready = 1'b1;
        step("fetch_go", ST_FETCH, c_fetch(1'b1));
        step("lw2_dec", ST_DECODE, c_decode());
        step("lw2_addr", ST_MEM_ADDR, c_mem_addr());
        mem_ready = 1'b0;
        step("lw2_wait1", ST_MEM_RD, c_mem_rd());
        step("lw2_wait2", ST_MEM_RD, c_mem_rd());
        reset = 1'b1;
        step("rst_mid", ST_MEM_RD, '0);
        reset     = 1'b0;
        mem_ready = 1'b1;
        step("after_rst", ST_FETCH, c_fetch(1'b1));
        step("after_dec", ST_DECODE, c_decode());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
